// File: rtl/lock_pkg.sv
// Shared types and key codes for the keypad combination lock receiver.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } lock_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/keycode_sync.sv
// Header-side front end: synchronizes the keypad code/valid pins and turns each
// qualified press into a one-cycle strobe with the captured key code.
module keycode_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code_in,
  input  logic       key_validn_in,
  output logic       key_strobe,
  output logic [3:0] key_value
);

  logic [3:0] code_s1;
  logic [3:0] code_s2;
  logic       vn_s1;
  logic       vn_s2;
  logic       vn_d1;
  logic       vn_d2;
  logic       press;

  // Synchronized validn history: low, low, preceded by high. A held key only
  // shows that pattern once, and a single low sample never completes it.
  assign press = !vn_s2 && !vn_d1 && vn_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_s1    <= 4'd0;
      code_s2    <= 4'd0;
      vn_s1      <= 1'b1;
      vn_s2      <= 1'b1;
      vn_d1      <= 1'b1;
      vn_d2      <= 1'b1;
      key_strobe <= 1'b0;
      key_value  <= 4'd0;
    end else begin
      code_s1    <= key_code_in;
      code_s2    <= code_s1;
      vn_s1      <= key_validn_in;
      vn_s2      <= vn_s1;
      vn_d1      <= vn_s2;
      vn_d2      <= vn_d1;
      key_strobe <= press;
      if (press) begin
        key_value <= code_s2;
      end
    end
  end

endmodule

// File: rtl/keypad_lock_rx.sv
// Keypad link receiver plus combination-lock FSM: digit entry, combination
// check, timed unlocked/error/lockout indications and a consecutive-failure count.
module keypad_lock_rx
  import lock_pkg::*;
#(
  parameter int          DIGITS      = 4,
  parameter logic [31:0] COMBO       = 32'h0000_1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          ERR_CYCLES  = 25_000_000,
  parameter int          OPEN_CYCLES = 250_000_000,
  parameter int          LOCK_CYCLES = 500_000_000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic [3:0]  key_code_in,
  input  logic        key_validn_in,
  output logic        key_strobe,
  output logic [3:0]  key_value,
  output logic [3:0]  digit_count,
  output logic [31:0] entry,
  output logic        unlocked,
  output logic        error,
  output logic        lockout,
  output logic [2:0]  fail_count,
  output lock_state_t state
);

  localparam logic [63:0] MASK64       = (64'd1 << (4 * DIGITS)) - 64'd1;
  localparam logic [31:0] COMBO_MASKED = COMBO & MASK64[31:0];
  localparam logic [3:0]  DIGITS4      = 4'(DIGITS);
  localparam logic [2:0]  MAX_FAIL3    = 3'(MAX_FAIL);
  localparam logic [31:0] ERR_LOAD     = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] OPEN_LOAD    = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD    = 32'(LOCK_CYCLES - 1);

  logic [31:0] timer;
  logic [2:0]  fail_next;
  logic        match;

  keycode_sync u_sync (
    .clk          (MAX10_CLK1_50),
    .rst_n        (rst),
    .key_code_in  (key_code_in),
    .key_validn_in(key_validn_in),
    .key_strobe   (key_strobe),
    .key_value    (key_value)
  );

  assign fail_next = fail_count + 3'd1;
  assign match     = (digit_count == DIGITS4) && (entry == COMBO_MASKED);

  // Timed states hold for N cycles: timer is loaded with N-1 on entry and the
  // state leaves on the cycle after it reads zero. Expiry wins over any strobe.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      entry       <= 32'd0;
      digit_count <= 4'd0;
      fail_count  <= 3'd0;
      timer       <= 32'd0;
      unlocked    <= 1'b0;
      error       <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_strobe && is_digit(key_value)) begin
            entry       <= {28'd0, key_value};
            digit_count <= 4'd1;
            state       <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (key_strobe) begin
            if (is_digit(key_value)) begin
              // Upper nibbles are still zero while digit_count < DIGITS.
              if (digit_count < DIGITS4) begin
                entry       <= {entry[27:0], key_value};
                digit_count <= digit_count + 4'd1;
              end
            end else if (key_value == KEY_CLEAR) begin
              entry       <= 32'd0;
              digit_count <= 4'd0;
              state       <= ST_IDLE;
            end else if (key_value == KEY_ENTER) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          entry       <= 32'd0;
          digit_count <= 4'd0;
          if (match) begin
            fail_count <= 3'd0;
            unlocked   <= 1'b1;
            timer      <= OPEN_LOAD;
            state      <= ST_OPEN;
          end else begin
            fail_count <= fail_next;
            if (fail_next == MAX_FAIL3) begin
              lockout <= 1'b1;
              timer   <= LOCK_LOAD;
              state   <= ST_LOCKOUT;
            end else begin
              error <= 1'b1;
              timer <= ERR_LOAD;
              state <= ST_FAIL;
            end
          end
        end

        ST_OPEN: begin
          if (timer == 32'd0 || (key_strobe && key_value == KEY_CLEAR)) begin
            unlocked <= 1'b0;
            timer    <= 32'd0;
            state    <= ST_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        ST_FAIL: begin
          if (timer == 32'd0) begin
            error <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        ST_LOCKOUT: begin
          if (timer == 32'd0) begin
            lockout    <= 1'b0;
            fail_count <= 3'd0;
            state      <= ST_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_lock_rx.md
# keypad_lock_rx

Receiving end of the keypad link: takes the 4-bit key code and active-low valid strobe that the keypad scanner drives onto the Arduino header, synchronizes them into the local clock domain, and turns each key press into a single-cycle strobe. A combination-lock state machine consumes the strobes. It collects digits, checks them against a parameterized combination on enter, and drives unlocked, error and lockout indications, with a failure counter and timed lockout. The block sits on the lock-controller board between the header pins and the display/actuator logic.

## Interface
- DIGITS, 4: combination length in digits (1–8).
- COMBO, 32'h0000_1234: combination as BCD nibbles, right-aligned. The first-entered digit is nibble DIGITS-1.
- MAX_FAIL, 3: consecutive failed checks that trigger lockout (≥1).
- ERR_CYCLES, 25_000_000: error indication duration (≥1).
- OPEN_CYCLES, 250_000_000: unlocked duration (≥1).
- LOCK_CYCLES, 500_000_000: lockout duration (≥1).
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- rst  in  1  reset. Asynchronous, active-low.
- key_code_in  in  4  key code from header. Asynchronous to the clock.
- key_validn_in  in  1  key valid, active-low, held low while the key is held. Asynchronous.
- key_strobe  out  1  one-cycle pulse per accepted press.
- key_value  out  4  captured code. Valid with key_strobe and held until the next press.
- digit_count  out  4  digits currently entered (0..DIGITS).
- entry  out  32  entered digits as BCD, right-aligned, for HEX display.
- unlocked  out  1  high in OPEN.
- error  out  1  high in FAIL.
- lockout  out  1  high in LOCKOUT.
- fail_count  out  3  consecutive failures so far.

## Operation
- Key map:
  - 0x0–0x9: digit.
  - 0xA–0xD: ignored everywhere.
  - 0xE: ENTER ('#').
  - 0xF: CLEAR ('*').
- Front end:
  - All 5 inputs pass through a 2-FF synchronizer. The validn synchronizer flops reset to 1.
  - A press is accepted when synchronized validn has been low for 2 consecutive cycles after having been high.
  - key_value is captured from the synchronized code on that cycle, and key_strobe pulses.
  - Low pulses shorter than 2 cycles are rejected.
  - Holding a key produces exactly one strobe.
- FSM states: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT. Behaviour on a strobe:
  - IDLE:
    - digit → shift into entry, digit_count=1, go to ENTRY.
    - ENTER or CLEAR → no-op.
  - ENTRY:
    - digit with digit_count<DIGITS → entry={entry<<4 | digit}, digit_count+1.
    - digit with digit_count==DIGITS → ignored, no wrap and no shift-out.
    - CLEAR → entry=0, digit_count=0, go to IDLE.
    - ENTER → go to CHECK.
  - CHECK (one cycle, ignores strobes):
    - match when digit_count==DIGITS and entry==COMBO masked to DIGITS nibbles.
    - match → fail_count=0, go to OPEN.
    - mismatch → fail_count+1. If the new value equals MAX_FAIL, go to LOCKOUT; otherwise go to FAIL.
    - entry and digit_count clear on leaving CHECK.
  - OPEN: unlocked=1 for OPEN_CYCLES, then go to IDLE. CLEAR relocks immediately (go to IDLE). Other keys are ignored.
  - FAIL: error=1 for ERR_CYCLES, then go to IDLE. All keys are ignored.
  - LOCKOUT: lockout=1 for LOCK_CYCLES, then fail_count=0 and go to IDLE. All keys are ignored.
- One shared down-counter serves as the timer. It is loaded with N-1 on entry to a timed state, and the state exits on the cycle after it reads 0.
- Reset values: key_strobe 0, key_value 0, digit_count 0, entry 0, unlocked 0, error 0, lockout 0, fail_count 0, state IDLE, timer 0.
- Reset asserted mid-operation aborts any state and timer immediately. fail_count is cleared, so reset defeats lockout by design.

## Timing
- Let edge k be the first clock edge that samples key_validn_in low. key_strobe is high during cycle k+3 (after edge k+3) for exactly one cycle.
- The FSM reacts to a strobe at the next edge (k+4). Outputs are registered and change at that edge.
- CHECK lasts exactly 1 cycle.
- unlocked, error and lockout each stay high for exactly their parameter count of cycles.
- A strobe arriving on the same cycle as a timer expiry is ignored. The only exception is CLEAR in OPEN, which yields the same IDLE result.
- Rapid re-press: validn must read high for ≥1 synchronized cycle, then low for 2, before another strobe.

## Structure
- Package lock_pkg: state enum lock_state_t, constants KEY_ENTER=4'hE and KEY_CLEAR=4'hF, helper function is_digit.
- Sub-module keycode_sync: synchronizer, press qualification, key_value capture, key_strobe.
- Top: FSM, entry shift register, fail counter, timer.

## Test plan
Bench overrides timers to ERR_CYCLES=5, OPEN_CYCLES=10, LOCK_CYCLES=20.
- Press 1,2,3,4 then 0xE → digit_count 1..4, entry=0x1234, CHECK, unlocked high for exactly 10 cycles, then IDLE with entry 0.
- Press 1,2,3,5 then 0xE → error high 5 cycles, fail_count=1. Repeat twice more → third failure asserts lockout for 20 cycles, and fail_count is 0 afterwards.
- During lockout, press 1,2,3,4,0xE → no strobe effect, and unlocked stays 0.
- Press 1,2,3,4,5,0xE → fifth digit ignored (entry 0x1234), unlock. Separately, press 1,2,0xE → error (short entry). Press 1,0xF → entry 0, IDLE.
- validn low for 1 cycle → no strobe. Held low for 1000 cycles → one strobe at k+3 with correct key_value. Keys 0xA–0xD → digit_count unchanged.
- Assert rst during OPEN, and separately during LOCKOUT → all outputs return to reset values asynchronously. No spurious strobe after release while validn is high.
